tt_vpu_ovi_issue_queue: RTL and testbench
=========================================

# tt_vpu_ovi_issue_queue

Vector-side OVI issue queue that sits directly downstream of the OVI issue/dispatch bus and upstream of the vector execution front end. Buffers instructions arriving on `issue_valid`, holds each until the core declares it senior (`dispatch_next_senior`) or kills it (`dispatch_kill`), releases senior instructions in order to execution, and returns one `issue_credit` pulse per freed entry. Also flags OVI protocol violations on the issue/dispatch bus.

## Interface
- `DEPTH`, 4: number of entries; power of two, 2..16; the core's initial credit count equals DEPTH.
- `clk` in 1: clock; all state on rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `issue_valid` in 1: new instruction from the core.
- `issue_inst` in 32: instruction word.
- `issue_sb_id` in 5: scoreboard id.
- `issue_scalar_opnd` in 64: scalar operand.
- `issue_vcsr` in 40: vector CSR snapshot.
- `issue_vcsr_lmulb2` in 1: extra vlmul bit, stored as bit 40 of the vcsr field.
- `dispatch_next_senior` in 1: oldest undispatched entry becomes senior.
- `dispatch_kill` in 1: oldest undispatched entry is killed.
- `dispatch_sb_id` in 5: sb_id the dispatch event refers to.
- `issue_credit` out 1: one-cycle pulse per freed entry.
- `exe_valid` out 1: head entry is senior and offered to execution.
- `exe_ready` in 1: execution accepts the head this cycle.
- `exe_inst` out 32, `exe_sb_id` out 5, `exe_scalar_opnd` out 64, `exe_vcsr` out 41: head entry payload.
- `occupancy` out clog2(DEPTH)+1: entries currently held.
- `err_overflow` out 1: sticky; issue_valid seen while full.
- `err_dispatch` out 1: sticky; dispatch with no undispatched entry, sb_id mismatch, or senior and kill together.

## Operation
- Storage: circular buffer of DEPTH entries, each {inst, sb_id, scalar, vcsr[40:0], state}; state ∈ {PEND, SENIOR, KILLED}.
- Pointers `wr_ptr`, `disp_ptr`, `rd_ptr`, each clog2(DEPTH)+1 bits with wrap bit. Full when `wr_ptr - rd_ptr == DEPTH`; empty when equal. Ordering invariant: rd_ptr ≤ disp_ptr ≤ wr_ptr, modulo wrap.
- Issue: when `issue_valid` and not full, write the entry at wr_ptr with state PEND and increment wr_ptr. When full, drop the instruction, set err_overflow, and leave state unchanged.
- Dispatch: applies to the entry at disp_ptr. If disp_ptr == wr_ptr and `issue_valid` is asserted in the same cycle with `issue_sb_id == dispatch_sb_id`, it applies to the entry being written: the entry is written directly as SENIOR/KILLED. Senior sets SENIOR; kill sets KILLED; disp_ptr increments.
- Dispatch errors: if there is no target, stored sb_id ≠ dispatch_sb_id, or both senior and kill are asserted, set err_dispatch and make no state change.
- Head: when the head entry is SENIOR, `exe_valid`=1 with its payload. On `exe_valid & exe_ready`, rd_ptr increments. When the head entry is KILLED, rd_ptr increments without exe_valid. At most one entry leaves per cycle.
- Credit: any rd_ptr increment sets `issue_credit`=1 on the following cycle.
- `occupancy` = wr_ptr − rd_ptr, computed in pointer width. Occupancy drops when an entry leaves, not when it is killed.
- Error flags clear only on reset.

## Timing
- Reset values: all pointers 0, all states PEND, exe_valid 0, payload outputs 0, issue_credit 0, occupancy 0, both error flags 0. Reset mid-operation discards all entries and returns no credits; the core re-initialises to DEPTH credits.
- Issue-to-exe latency: issue with same-cycle senior at cycle N gives exe_valid at N+1 at the earliest. Senior at a later cycle M gives exe_valid at M+1 if the entry is at the head.
- Exe outputs are driven from registered state only; exe_valid does not depend combinationally on exe_ready. Payload holds stable while exe_valid=1 and exe_ready=0.
- A killed head is dropped in one cycle. issue_credit follows one cycle after any dequeue.
- Simultaneous issue + dequeue when full: the issue is still rejected, because fullness is evaluated before dequeue. The core must not issue without a credit.
- Pointer wrap: the wrap bit distinguishes full from empty. Behaviour must be verified across more than 2×DEPTH issues.

## Test plan
- Basic: issue sb 3 with same-cycle senior; exe_ready=1 → exe_valid at N+1 with exe_sb_id=3; issue_credit pulse at N+2; occupancy returns to 0.
- Kill: issue sb 1, 2; kill 1, senior 2 → only sb 2 reaches exe; two issue_credit pulses on consecutive cycles.
- Backpressure/full (DEPTH=4): issue 4, all senior, exe_ready=0 → occupancy=4, payload stable. A 5th issue → err_overflow=1, occupancy stays 4.
- Out-of-order dispatch: issue 5, 6; senior sb 6 first → err_dispatch=1, both entries remain PEND, exe_valid=0.
- Wrap: 40 back-to-back issue+senior with random exe_ready → in-order sb_ids on exe, total credits = 40, no errors.
- Reset mid-stream: assert reset_n=0 with 3 entries held → all outputs return to reset values asynchronously; no credit pulses after release.

Source files
------------

// File: rtl/tt_vpu_ovi_issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : tt_vpu_ovi_issue_queue_if
// Description : Bundle of the OVI issue/dispatch bus, the execution-side
//               handshake and the status outputs of the vector issue queue.
//               master = core / execution front end, slave = issue queue.
//   issue_*     : new instruction from the core (valid, inst, sb_id, scalar,
//                 vcsr, vcsr_lmulb2)
//   dispatch_*  : seniority / kill events for the oldest undispatched entry
//   issue_credit: one-cycle pulse per freed entry
//   exe_*       : head-entry offer to execution (valid/ready + payload)
//   occupancy, err_overflow, err_dispatch : status
// Revision    : 1.0 - initial release
// ============================================================================
interface tt_vpu_ovi_issue_queue_if #(
    parameter int DEPTH = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             issue_valid;
    logic [31:0]      issue_inst;
    logic [4:0]       issue_sb_id;
    logic [63:0]      issue_scalar_opnd;
    logic [39:0]      issue_vcsr;
    logic             issue_vcsr_lmulb2;
    logic             dispatch_next_senior;
    logic             dispatch_kill;
    logic [4:0]       dispatch_sb_id;
    logic             issue_credit;
    logic             exe_valid;
    logic             exe_ready;
    logic [31:0]      exe_inst;
    logic [4:0]       exe_sb_id;
    logic [63:0]      exe_scalar_opnd;
    logic [40:0]      exe_vcsr;
    logic [OCC_W-1:0] occupancy;
    logic             err_overflow;
    logic             err_dispatch;

    modport master (
        output issue_valid, issue_inst, issue_sb_id, issue_scalar_opnd,
               issue_vcsr, issue_vcsr_lmulb2,
               dispatch_next_senior, dispatch_kill, dispatch_sb_id, exe_ready,
        input  issue_credit, exe_valid, exe_inst, exe_sb_id, exe_scalar_opnd,
               exe_vcsr, occupancy, err_overflow, err_dispatch
    );

    modport slave (
        input  issue_valid, issue_inst, issue_sb_id, issue_scalar_opnd,
               issue_vcsr, issue_vcsr_lmulb2,
               dispatch_next_senior, dispatch_kill, dispatch_sb_id, exe_ready,
        output issue_credit, exe_valid, exe_inst, exe_sb_id, exe_scalar_opnd,
               exe_vcsr, occupancy, err_overflow, err_dispatch
    );
endinterface
`default_nettype wire

// File: rtl/tt_vpu_ovi_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tt_vpu_ovi_issue_queue
// Description : Vector-side OVI issue queue. Buffers issued instructions in a
//               circular buffer, marks them senior/killed as the core
//               dispatches them in order, offers senior heads to execution,
//               silently drops killed heads and returns one credit per freed
//               entry. Flags overflow and dispatch protocol errors (sticky).
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : tt_vpu_ovi_issue_queue_if.slave (issue, dispatch, exe, status)
// Revision    : 1.0 - initial release
// ============================================================================
module tt_vpu_ovi_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    tt_vpu_ovi_issue_queue_if.slave    bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_PEND   = 2'd0,
        ST_SENIOR = 2'd1,
        ST_KILLED = 2'd2
    } ent_state_e;

    logic [31:0] inst_q   [DEPTH];
    logic [4:0]  sb_q     [DEPTH];
    logic [63:0] scalar_q [DEPTH];
    logic [40:0] vcsr_q   [DEPTH];
    ent_state_e  state_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] disp_ptr_q, disp_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic             credit_q,   credit_d;
    logic             err_ovf_q,  err_ovf_d;
    logic             err_disp_q, err_disp_d;

    logic [IDX_W-1:0] wr_idx, disp_idx, rd_idx;
    logic [PTR_W-1:0] occ;
    logic             full, empty, do_issue;
    logic             disp_req, disp_both, pend_avail, same_cycle_tgt, disp_ok;
    logic             deq;
    ent_state_e       disp_state, issue_state, head_state;

    assign wr_idx   = wr_ptr_q[IDX_W-1:0];
    assign disp_idx = disp_ptr_q[IDX_W-1:0];
    assign rd_idx   = rd_ptr_q[IDX_W-1:0];

    // Fullness is judged on the registered pointers, so an issue arriving in
    // the same cycle as a dequeue from a full queue is still rejected.
    assign occ      = wr_ptr_q - rd_ptr_q;
    assign full     = (occ == PTR_W'(DEPTH));
    assign empty    = (occ == '0);
    assign do_issue = bus.issue_valid & ~full;

    // The dispatch target is the oldest undispatched stored entry; when none
    // exists it may be the entry being written this cycle, matched by sb_id.
    assign disp_req       = bus.dispatch_next_senior | bus.dispatch_kill;
    assign disp_both      = bus.dispatch_next_senior & bus.dispatch_kill;
    assign pend_avail     = (disp_ptr_q != wr_ptr_q);
    assign same_cycle_tgt = ~pend_avail & do_issue &
                            (bus.issue_sb_id == bus.dispatch_sb_id);
    assign disp_ok        = disp_req & ~disp_both &
                            (pend_avail ? (sb_q[disp_idx] == bus.dispatch_sb_id)
                                        : same_cycle_tgt);
    assign disp_state     = bus.dispatch_next_senior ? ST_SENIOR : ST_KILLED;
    assign issue_state    = (disp_ok & ~pend_avail) ? disp_state : ST_PEND;

    // Only the registered head state drives exe_valid; exe_ready merely
    // decides whether the offered entry leaves.
    assign head_state = state_q[rd_idx];
    assign deq        = ~empty & ((head_state == ST_KILLED) |
                                  ((head_state == ST_SENIOR) & bus.exe_ready));

    always_comb begin
        wr_ptr_d   = wr_ptr_q   + (do_issue ? PTR_W'(1) : '0);
        disp_ptr_d = disp_ptr_q + (disp_ok  ? PTR_W'(1) : '0);
        rd_ptr_d   = rd_ptr_q   + (deq      ? PTR_W'(1) : '0);
        credit_d   = deq;
        err_ovf_d  = err_ovf_q  | (bus.issue_valid & full);
        err_disp_d = err_disp_q | (disp_req & ~disp_ok);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i]   <= '0;
                sb_q[i]     <= '0;
                scalar_q[i] <= '0;
                vcsr_q[i]   <= '0;
                state_q[i]  <= ST_PEND;
            end
            wr_ptr_q   <= '0;
            disp_ptr_q <= '0;
            rd_ptr_q   <= '0;
            credit_q   <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_disp_q <= 1'b0;
        end else begin
            if (do_issue) begin
                inst_q[wr_idx]   <= bus.issue_inst;
                sb_q[wr_idx]     <= bus.issue_sb_id;
                scalar_q[wr_idx] <= bus.issue_scalar_opnd;
                vcsr_q[wr_idx]   <= {bus.issue_vcsr_lmulb2, bus.issue_vcsr};
                state_q[wr_idx]  <= issue_state;
            end
            // disp_idx can equal wr_idx only when full, where no issue occurs.
            if (disp_ok && pend_avail) begin
                state_q[disp_idx] <= disp_state;
            end
            wr_ptr_q   <= wr_ptr_d;
            disp_ptr_q <= disp_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            credit_q   <= credit_d;
            err_ovf_q  <= err_ovf_d;
            err_disp_q <= err_disp_d;
        end
    end

    assign bus.exe_valid       = ~empty & (head_state == ST_SENIOR);
    assign bus.exe_inst        = inst_q[rd_idx];
    assign bus.exe_sb_id       = sb_q[rd_idx];
    assign bus.exe_scalar_opnd = scalar_q[rd_idx];
    assign bus.exe_vcsr        = vcsr_q[rd_idx];
    assign bus.issue_credit    = credit_q;
    assign bus.occupancy       = occ;
    assign bus.err_overflow    = err_ovf_q;
    assign bus.err_dispatch    = err_disp_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_vpu_ovi_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_vpu_ovi_issue_queue
// Description : Directed self-checking bench for tt_vpu_ovi_issue_queue
//               (DEPTH = 4). Inputs change and outputs are sampled 1 ns after
//               each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_vpu_ovi_issue_queue;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    tt_vpu_ovi_issue_queue_if #(.DEPTH(4)) bus ();

    tt_vpu_ovi_issue_queue #(.DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid          = 1'b0;
        bus.issue_inst           = '0;
        bus.issue_sb_id          = '0;
        bus.issue_scalar_opnd    = '0;
        bus.issue_vcsr           = '0;
        bus.issue_vcsr_lmulb2    = 1'b0;
        bus.dispatch_next_senior = 1'b0;
        bus.dispatch_kill        = 1'b0;
        bus.dispatch_sb_id       = '0;
        bus.exe_ready            = 1'b0;
    endtask

    // Payload is a fixed function of sb_id so expectations can be rebuilt.
    task automatic drive_issue(input logic [4:0] sb, input logic sen);
        bus.issue_valid       = 1'b1;
        bus.issue_sb_id       = sb;
        bus.issue_inst        = 32'hC0DE_0000 | {27'h0, sb};
        bus.issue_scalar_opnd = {32'hFACE_0000, 27'h0, sb};
        bus.issue_vcsr        = 40'h12_3456_0000 | {35'h0, sb};
        bus.issue_vcsr_lmulb2 = sb[0];
        if (sen) begin
            bus.dispatch_next_senior = 1'b1;
            bus.dispatch_sb_id       = sb;
        end
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.exe_valid !== 1'b0) begin n_err++; $display("FAIL reset_exe_valid: got %b exp 0", bus.exe_valid); end
        n_cmp++; if (bus.issue_credit !== 1'b0) begin n_err++; $display("FAIL reset_credit: got %b exp 0", bus.issue_credit); end
        n_cmp++; if (bus.occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ: got %0d exp 0", bus.occupancy); end
        n_cmp++; if ({bus.err_overflow, bus.err_dispatch} !== 2'b00) begin n_err++; $display("FAIL reset_errs: got %b%b exp 00", bus.err_overflow, bus.err_dispatch); end
        n_cmp++; if ({bus.exe_inst, bus.exe_sb_id, bus.exe_scalar_opnd, bus.exe_vcsr} !== 142'd0) begin n_err++; $display("FAIL reset_payload: got nonzero sb=%0d inst=%h exp 0", bus.exe_sb_id, bus.exe_inst); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        drive_issue(5'd3, 1'b1);
        bus.exe_ready = 1'b1;
        tick();
        idle();
        bus.exe_ready = 1'b1;
        n_cmp++; if (bus.exe_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b exp 1", bus.exe_valid); end
        n_cmp++; if (bus.exe_sb_id !== 5'd3) begin n_err++; $display("FAIL basic_sb: got %0d exp 3", bus.exe_sb_id); end
        n_cmp++; if (bus.exe_inst !== 32'hC0DE_0003) begin n_err++; $display("FAIL basic_inst: got %h exp c0de0003", bus.exe_inst); end
        n_cmp++; if (bus.exe_scalar_opnd !== 64'hFACE_0000_0000_0003) begin n_err++; $display("FAIL basic_scalar: got %h exp face000000000003", bus.exe_scalar_opnd); end
        n_cmp++; if (bus.exe_vcsr !== 41'h112_3456_0003) begin n_err++; $display("FAIL basic_vcsr: got %h exp 11234560003", bus.exe_vcsr); end
        n_cmp++; if (bus.occupancy !== 3'd1 || bus.issue_credit !== 1'b0) begin n_err++; $display("FAIL basic_occ1: got occ=%0d credit=%b exp occ=1 credit=0", bus.occupancy, bus.issue_credit); end
        tick();
        n_cmp++; if (bus.issue_credit !== 1'b1 || bus.occupancy !== 3'd0 || bus.exe_valid !== 1'b0) begin n_err++; $display("FAIL basic_credit: got credit=%b occ=%0d valid=%b exp 1 0 0", bus.issue_credit, bus.occupancy, bus.exe_valid); end
        tick();
        n_cmp++; if (bus.issue_credit !== 1'b0) begin n_err++; $display("FAIL basic_credit_end: got %b exp 0", bus.issue_credit); end
    endtask

    task automatic test_kill();
        do_reset();
        drive_issue(5'd1, 1'b0); tick(); idle();
        drive_issue(5'd2, 1'b0); tick(); idle();
        bus.dispatch_kill = 1'b1; bus.dispatch_sb_id = 5'd1;
        tick(); idle();
        n_cmp++; if (bus.occupancy !== 3'd2 || bus.exe_valid !== 1'b0 || bus.issue_credit !== 1'b0) begin n_err++; $display("FAIL kill_marked: got occ=%0d valid=%b credit=%b exp 2 0 0", bus.occupancy, bus.exe_valid, bus.issue_credit); end
        bus.dispatch_next_senior = 1'b1; bus.dispatch_sb_id = 5'd2; bus.exe_ready = 1'b1;
        tick(); idle();
        bus.exe_ready = 1'b1;
        n_cmp++; if (bus.issue_credit !== 1'b1 || bus.occupancy !== 3'd1) begin n_err++; $display("FAIL kill_drop: got credit=%b occ=%0d exp 1 1", bus.issue_credit, bus.occupancy); end
        n_cmp++; if (bus.exe_valid !== 1'b1 || bus.exe_sb_id !== 5'd2) begin n_err++; $display("FAIL kill_next: got valid=%b sb=%0d exp 1 2", bus.exe_valid, bus.exe_sb_id); end
        tick(); idle();
        n_cmp++; if (bus.issue_credit !== 1'b1 || bus.occupancy !== 3'd0 || bus.exe_valid !== 1'b0) begin n_err++; $display("FAIL kill_second_credit: got credit=%b occ=%0d valid=%b exp 1 0 0", bus.issue_credit, bus.occupancy, bus.exe_valid); end
        n_cmp++; if (bus.err_dispatch !== 1'b0 || bus.err_overflow !== 1'b0) begin n_err++; $display("FAIL kill_errs: got ovf=%b disp=%b exp 0 0", bus.err_overflow, bus.err_dispatch); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle();
            drive_issue(5'(10 + i), 1'b1);
            tick();
        end
        idle();
        n_cmp++; if (bus.occupancy !== 3'd4 || bus.exe_valid !== 1'b1 || bus.exe_sb_id !== 5'd10) begin n_err++; $display("FAIL full_occ: got occ=%0d valid=%b sb=%0d exp 4 1 10", bus.occupancy, bus.exe_valid, bus.exe_sb_id); end
        tick();
        n_cmp++; if (bus.exe_inst !== 32'hC0DE_000A || bus.exe_sb_id !== 5'd10 || bus.exe_valid !== 1'b1) begin n_err++; $display("FAIL full_stable: got inst=%h sb=%0d exp c0de000a 10", bus.exe_inst, bus.exe_sb_id); end
        drive_issue(5'd14, 1'b0);
        tick(); idle();
        n_cmp++; if (bus.err_overflow !== 1'b1 || bus.occupancy !== 3'd4 || bus.err_dispatch !== 1'b0) begin n_err++; $display("FAIL full_overflow: got ovf=%b occ=%0d disp=%b exp 1 4 0", bus.err_overflow, bus.occupancy, bus.err_dispatch); end
        drive_issue(5'd15, 1'b0);
        bus.exe_ready = 1'b1;
        tick(); idle();
        bus.exe_ready = 1'b1;
        n_cmp++; if (bus.occupancy !== 3'd3 || bus.exe_sb_id !== 5'd11 || bus.issue_credit !== 1'b1) begin n_err++; $display("FAIL full_issue_deq: got occ=%0d sb=%0d credit=%b exp 3 11 1", bus.occupancy, bus.exe_sb_id, bus.issue_credit); end
        tick();
        n_cmp++; if (bus.exe_sb_id !== 5'd12 || bus.exe_inst !== 32'hC0DE_000C) begin n_err++; $display("FAIL full_drain12: got sb=%0d inst=%h exp 12 c0de000c", bus.exe_sb_id, bus.exe_inst); end
        tick();
        n_cmp++; if (bus.exe_sb_id !== 5'd13 || bus.exe_valid !== 1'b1) begin n_err++; $display("FAIL full_drain13: got sb=%0d valid=%b exp 13 1", bus.exe_sb_id, bus.exe_valid); end
        tick(); idle();
        n_cmp++; if (bus.occupancy !== 3'd0 || bus.exe_valid !== 1'b0 || bus.err_overflow !== 1'b1) begin n_err++; $display("FAIL full_empty: got occ=%0d valid=%b ovf=%b exp 0 0 1", bus.occupancy, bus.exe_valid, bus.err_overflow); end
    endtask

    task automatic test_ooo_dispatch();
        do_reset();
        bus.dispatch_next_senior = 1'b1; bus.dispatch_sb_id = 5'd0;
        tick(); idle();
        n_cmp++; if (bus.err_dispatch !== 1'b1 || bus.occupancy !== 3'd0) begin n_err++; $display("FAIL ooo_no_target: got disp=%b occ=%0d exp 1 0", bus.err_dispatch, bus.occupancy); end
        do_reset();
        drive_issue(5'd5, 1'b0); tick(); idle();
        drive_issue(5'd6, 1'b0); tick(); idle();
        bus.dispatch_next_senior = 1'b1; bus.dispatch_sb_id = 5'd6; bus.exe_ready = 1'b1;
        tick(); idle();
        n_cmp++; if (bus.err_dispatch !== 1'b1 || bus.exe_valid !== 1'b0 || bus.occupancy !== 3'd2) begin n_err++; $display("FAIL ooo_err: got disp=%b valid=%b occ=%0d exp 1 0 2", bus.err_dispatch, bus.exe_valid, bus.occupancy); end
        bus.dispatch_next_senior = 1'b1; bus.dispatch_sb_id = 5'd5;
        tick(); idle();
        n_cmp++; if (bus.exe_valid !== 1'b1 || bus.exe_sb_id !== 5'd5) begin n_err++; $display("FAIL ooo_head_pending: got valid=%b sb=%0d exp 1 5", bus.exe_valid, bus.exe_sb_id); end
        bus.dispatch_next_senior = 1'b1; bus.dispatch_kill = 1'b1; bus.dispatch_sb_id = 5'd6;
        tick(); idle();
        bus.dispatch_next_senior = 1'b1; bus.dispatch_sb_id = 5'd6; bus.exe_ready = 1'b1;
        tick(); idle();
        n_cmp++; if (bus.exe_valid !== 1'b1 || bus.exe_sb_id !== 5'd6 || bus.occupancy !== 3'd1) begin n_err++; $display("FAIL ooo_both_ignored: got valid=%b sb=%0d occ=%0d exp 1 6 1", bus.exe_valid, bus.exe_sb_id, bus.occupancy); end
    endtask

    task automatic test_wrap();
        int credits, issued, got_cred, deq_cnt, cyc;
        int exp_q[$];
        int exp_sb;
        do_reset();
        credits = 4; issued = 0; got_cred = 0; deq_cnt = 0; cyc = 0;
        while (got_cred < 40 && cyc < 2000) begin
            if (bus.issue_credit === 1'b1) begin credits++; got_cred++; end
            idle();
            if (issued < 40 && credits > 0) begin
                drive_issue(5'(issued % 32), 1'b1);
                exp_q.push_back(issued % 32);
                credits--;
                issued++;
            end
            bus.exe_ready = 1'($urandom_range(0, 1));
            if (bus.exe_valid === 1'b1 && bus.exe_ready === 1'b1) begin
                exp_sb = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                n_cmp++; if (exp_sb < 0 || bus.exe_sb_id !== 5'(exp_sb)) begin n_err++; $display("FAIL wrap_order: got sb=%0d exp %0d at dequeue %0d", bus.exe_sb_id, exp_sb, deq_cnt); end
                deq_cnt++;
            end
            tick();
            cyc++;
        end
        idle();
        n_cmp++; if (cyc >= 2000) begin n_err++; $display("FAIL wrap_timeout: got %0d cycles exp < 2000", cyc); end
        n_cmp++; if (got_cred != 40 || deq_cnt != 40) begin n_err++; $display("FAIL wrap_counts: got credits=%0d deq=%0d exp 40 40", got_cred, deq_cnt); end
        n_cmp++; if (bus.err_overflow !== 1'b0 || bus.err_dispatch !== 1'b0 || bus.occupancy !== 3'd0) begin n_err++; $display("FAIL wrap_end: got ovf=%b disp=%b occ=%0d exp 0 0 0", bus.err_overflow, bus.err_dispatch, bus.occupancy); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        do_reset();
        drive_issue(5'd20, 1'b1); tick(); idle();
        drive_issue(5'd21, 1'b0); tick(); idle();
        drive_issue(5'd22, 1'b0); tick(); idle();
        n_cmp++; if (bus.occupancy !== 3'd3 || bus.exe_valid !== 1'b1 || bus.exe_sb_id !== 5'd20) begin n_err++; $display("FAIL rstmid_pre: got occ=%0d valid=%b sb=%0d exp 3 1 20", bus.occupancy, bus.exe_valid, bus.exe_sb_id); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.occupancy !== 3'd0 || bus.exe_valid !== 1'b0 || bus.exe_sb_id !== 5'd0 || bus.issue_credit !== 1'b0) begin n_err++; $display("FAIL rstmid_async: got occ=%0d valid=%b sb=%0d credit=%b exp 0 0 0 0", bus.occupancy, bus.exe_valid, bus.exe_sb_id, bus.issue_credit); end
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        bus.exe_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.issue_credit !== 1'b0) pulses++;
        end
        idle();
        n_cmp++; if (pulses != 0 || bus.occupancy !== 3'd0) begin n_err++; $display("FAIL rstmid_no_credit: got pulses=%0d occ=%0d exp 0 0", pulses, bus.occupancy); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_kill();
        test_full();
        test_ooo_dispatch();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
